led_pattern_driver: RTL and testbench

Multi-channel LED driver and the successor to the single-LED toggle block. It drives CHANNELS board LED pins from one prescaled timebase. Each channel has its own mode (off, steady, blink, breathe) and an 8-bit-class PWM brightness. Sits between the block_clock output and the board LED pins; channels are configured through a simple valid/ready write port.

---
 rtl/led_pattern_driver.sv | 156 +++++++++++++++
 tb/tb_led_pattern_driver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_driver.sv
// Multi-channel LED driver: shared prescaled tick, global blink phase and per-channel PWM modes.
// Define LED_PATTERN_BREATHE_EN to build the per-channel breathe ramp (mode 3); otherwise mode 3 acts as OFF.
module led_pattern_driver #(
   parameter int CHANNELS   = 8,
   parameter int PRESCALE_W = 22,
   parameter int PWM_W      = 8,
   parameter int CHAN_W     = 4
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CHAN_W-1:0]   cfg_chan,
   input  logic [1:0]          cfg_mode,
   input  logic [PWM_W-1:0]    cfg_duty,
   output logic                cfg_err,
   output logic                tick,
   output logic [CHANNELS-1:0] led_out
);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_e;

   localparam logic [PWM_W-1:0]  DUTY_FULL  = '1;
   localparam logic [CHAN_W:0]   CHAN_LIMIT = (CHAN_W+1)'(CHANNELS);

   logic [PRESCALE_W-1:0] prescaler_q;
   logic [PWM_W-1:0]      pwm_cnt_q;
   logic                  tick_q;
   logic                  blink_q;
   logic                  ready_q;
   logic                  err_q;
   logic                  accept;
   logic                  chan_bad;

   assign accept    = cfg_valid && ready_q;
   assign chan_bad  = ({1'b0, cfg_chan} >= CHAN_LIMIT);
   assign cfg_ready = ready_q;
   assign cfg_err   = err_q;
   assign tick      = tick_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         prescaler_q <= '0;
         pwm_cnt_q   <= '0;
         tick_q      <= 1'b0;
         blink_q     <= 1'b0;
         ready_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         prescaler_q <= prescaler_q + 1'b1;
         tick_q      <= &prescaler_q;
         // Global phase keeps toggling even when a write lands on the tick cycle.
         blink_q     <= blink_q ^ tick_q;
         pwm_cnt_q   <= pwm_cnt_q + 1'b1;
         ready_q     <= 1'b1;
         err_q       <= accept && chan_bad;
      end
   end

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      mode_e            mode_q;
      logic [PWM_W-1:0] duty_q;
      logic             led_q;
      logic             led_d;
      logic             wr_hit;
      logic             pwm_on;
      logic             breathe_on;

      assign wr_hit = accept && (cfg_chan == CHAN_W'(gi));
      assign pwm_on = (duty_q == DUTY_FULL) ||
                      ((duty_q != '0) && (pwm_cnt_q < duty_q));

`ifdef LED_PATTERN_BREATHE_EN
      logic [PWM_W-1:0] ramp_q;
      logic [PWM_W-1:0] ramp_d;
      logic             dir_down_q;
      logic             dir_down_d;

      // Triangle ramp between 0 and duty, one step per tick; a write restarts it.
      always_comb begin
         ramp_d     = ramp_q;
         dir_down_d = dir_down_q;
         if (tick_q && (mode_q == MODE_BREATHE)) begin
            if (!dir_down_q) begin
               if (ramp_q < duty_q) begin
                  ramp_d = ramp_q + 1'b1;
                  if ((ramp_q + 1'b1) == duty_q) dir_down_d = 1'b1;
               end else begin
                  dir_down_d = 1'b1;
               end
            end else begin
               if (ramp_q != '0) begin
                  ramp_d = ramp_q - 1'b1;
                  if (ramp_q == PWM_W'(1)) dir_down_d = 1'b0;
               end else begin
                  dir_down_d = 1'b0;
               end
            end
         end
         if (wr_hit) begin
            ramp_d     = '0;
            dir_down_d = 1'b0;
         end
      end

      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            ramp_q     <= '0;
            dir_down_q <= 1'b0;
         end else begin
            ramp_q     <= ramp_d;
            dir_down_q <= dir_down_d;
         end
      end

      assign breathe_on = (duty_q != '0) &&
                          ((ramp_q == DUTY_FULL) ||
                           ((ramp_q != '0) && (pwm_cnt_q < ramp_q)));
`else
      assign breathe_on = 1'b0;
`endif

      always_comb begin
         led_d = 1'b0;
         case (mode_q)
            MODE_OFF:     led_d = 1'b0;
            MODE_ON:      led_d = pwm_on;
            MODE_BLINK:   led_d = pwm_on && blink_q;
            MODE_BREATHE: led_d = breathe_on;
            default:      led_d = 1'b0;
         endcase
      end

      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            mode_q <= MODE_OFF;
            duty_q <= '0;
            led_q  <= 1'b0;
         end else begin
            if (wr_hit) begin
               mode_q <= mode_e'(cfg_mode);
               duty_q <= cfg_duty;
            end
            led_q <= led_d;
         end
      end

      assign led_out[gi] = led_q;
   end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed self-checking bench for led_pattern_driver (4 channels, 16-cycle tick and PWM period).
module tb_led_pattern_driver;

   localparam int CHANNELS   = 4;
   localparam int PRESCALE_W = 4;
   localparam int PWM_W      = 4;
   localparam int CHAN_W     = 3;

   logic                clk = 1'b0;
   logic                resetn = 1'b0;
   logic                cfg_valid = 1'b0;
   logic                cfg_ready;
   logic [CHAN_W-1:0]   cfg_chan = '0;
   logic [1:0]          cfg_mode = '0;
   logic [PWM_W-1:0]    cfg_duty = '0;
   logic                cfg_err;
   logic                tick;
   logic [CHANNELS-1:0] led_out;

   int total = 0;
   int bad   = 0;
   int edge_k;
   int first_tick;
   int on_cnt;

   led_pattern_driver #(
      .CHANNELS  (CHANNELS),
      .PRESCALE_W(PRESCALE_W),
      .PWM_W     (PWM_W),
      .CHAN_W    (CHAN_W)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_chan (cfg_chan),
      .cfg_mode (cfg_mode),
      .cfg_duty (cfg_duty),
      .cfg_err  (cfg_err),
      .tick     (tick),
      .led_out  (led_out)
   );

   always #5 clk = ~clk;

   // Number of rising edges since the last reset release.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) edge_k <= 0;
      else         edge_k <= edge_k + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, edge_k);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic cfg_write(input int chan, input int mode, input int duty);
      cfg_valid = 1'b1;
      cfg_chan  = CHAN_W'(chan);
      cfg_mode  = 2'(mode);
      cfg_duty  = PWM_W'(duty);
      step();
      cfg_valid = 1'b0;
      $display("cfg write: chan=%0d mode=%0d duty=%0d at edge %0d", chan, mode, duty, edge_k);
   endtask

   // LED state after edge k depends on counters as they stood after edge k-1.
   function automatic logic pwm_exp(input int k, input int d);
      return (d == 15) || (((k - 1) % 16) < d);
   endfunction

   function automatic logic blink_at(input int k);
      return (k >= 17) && ((((k - 1) / 16) % 2) == 1);
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int breathe_seq [8] = '{1, 2, 3, 2, 1, 0, 1, 2};

   initial begin
      // Reset held with a pending write.
      cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_mode = 2'd1; cfg_duty = 4'd15;
      resetn = 1'b0;
      repeat (5) step();
      check_val("rst_led",   32'(led_out),   32'd0);
      check_val("rst_tick",  32'(tick),      32'd0);
      check_val("rst_ready", 32'(cfg_ready), 32'd0);
      check_val("rst_err",   32'(cfg_err),   32'd0);
      resetn = 1'b1;
      step();
      check_val("ready_after_e1", 32'(cfg_ready), 32'd1);
      check_val("no_accept_e1",   32'(led_out),   32'd0);
      cfg_valid = 1'b0;
      step();
      check_val("no_accept_e2", 32'(led_out), 32'd0);

      // Tick cadence.
      first_tick = 0;
      while (edge_k < 40) begin
         step();
         check_val("tick", 32'(tick), 32'((edge_k >= 16) && (edge_k % 16 == 0)));
         if (tick && first_tick == 0) first_tick = edge_k;
      end
      check_val("first_tick", 32'(first_tick), 32'd16);

      // Steady PWM on channel 1.
      cfg_write(1, 1, 4);
      step();
      repeat (32) begin
         step();
         check_val("on_duty4", 32'(led_out), 32'({2'b00, pwm_exp(edge_k, 4), 1'b0}));
      end
      cfg_write(1, 1, 15);
      step();
      repeat (20) begin
         step();
         check_val("on_duty15", 32'(led_out), 32'd2);
      end
      cfg_write(1, 1, 0);
      step();
      repeat (20) begin
         step();
         check_val("on_duty0", 32'(led_out), 32'd0);
      end

      // Blink on channel 2.
      cfg_write(2, 2, 15);
      step();
      repeat (48) begin
         step();
         check_val("blink", 32'(led_out), 32'({1'b0, blink_at(edge_k - 1), 2'b00}));
      end

      // Write-to-output latency on channel 0.
      cfg_write(0, 1, 15);
      check_val("lat_edge_n", 32'(led_out[0]), 32'd0);
      step();
      check_val("lat_edge_n1", 32'(led_out[0]), 32'd1);

      // Out-of-range writes.
      cfg_write(5, 1, 15);
      check_val("err_chan5", 32'(cfg_err), 32'd1);
      check_val("err_chan5_led", 32'(led_out), 32'({1'b0, blink_at(edge_k - 1), 2'b01}));
      step();
      check_val("err_one_cycle", 32'(cfg_err), 32'd0);
      check_val("err_led_after", 32'(led_out), 32'({1'b0, blink_at(edge_k - 1), 2'b01}));
      cfg_write(4, 1, 15);
      check_val("err_chan4", 32'(cfg_err), 32'd1);
      cfg_write(3, 0, 0);
      check_val("noerr_chan3", 32'(cfg_err), 32'd0);
      check_val("ready_steady", 32'(cfg_ready), 32'd1);

      // Collision: OFF write to channel 2 on a tick cycle, channel 1 blinking.
      cfg_write(1, 2, 15);
      for (int i = 0; i < 40 && tick !== 1'b1; i++) step();
      check_val("col_tick_seen", 32'(tick), 32'd1);
      cfg_write(2, 0, 15);
      step();
      check_val("col_led2_off", 32'(led_out[2]), 32'd0);
      repeat (40) begin
         step();
         check_val("col_blink", 32'(led_out), 32'({2'b00, blink_at(edge_k - 1), 1'b1}));
      end

      // Breathe on channel 3, written away from a tick edge.
      for (int i = 0; i < 20 && (edge_k % 16) != 5; i++) step();
      cfg_write(3, 3, 3);
      for (int i = 0; i < 20 && (edge_k % 16) != 1; i++) step();
      check_val("breathe_align", 32'(edge_k % 16), 32'd1);
      for (int p = 0; p < 8; p++) begin
         on_cnt = 0;
         repeat (16) begin
            step();
            on_cnt += int'(led_out[3]);
         end
`ifdef LED_PATTERN_BREATHE_EN
         check_val($sformatf("breathe_p%0d", p), 32'(on_cnt), 32'(breathe_seq[p]));
`else
         check_val($sformatf("breathe_off_p%0d", p), 32'(on_cnt), 32'd0);
`endif
      end

      // Asynchronous reset mid-operation.
      check_val("pre_rst_led0", 32'(led_out[0]), 32'd1);
      @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      check_val("mid_rst_led",   32'(led_out),   32'd0);
      check_val("mid_rst_tick",  32'(tick),      32'd0);
      check_val("mid_rst_ready", 32'(cfg_ready), 32'd0);
      step();
      resetn = 1'b1;
      repeat (20) begin
         step();
         check_val("post_rst_led",  32'(led_out), 32'd0);
         check_val("post_rst_tick", 32'(tick), 32'((edge_k >= 16) && (edge_k % 16 == 0)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
